// File: rtl/ram_b_pkg.sv
// Shared sizing helpers and types for the layered partial-sum (beta) store.
package ram_b_pkg;

  localparam int unsigned Q_DEFAULT = 6;

  typedef logic [Q_DEFAULT-1:0] soft_t;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Number of stored layers for code length n
  function automatic int unsigned layers_of(input int unsigned n);
    return $clog2(n) - 1;
  endfunction

  // Values written per half in one beat
  function automatic int unsigned w_of(input int unsigned l, input int unsigned p);
    return min_u(32'd1 << (l - 1), p);
  endfunction

  // Values returned per read beat
  function automatic int unsigned r_of(input int unsigned l, input int unsigned p);
    return min_u(32'd1 << l, p);
  endfunction

  function automatic int unsigned wb_of(input int unsigned l, input int unsigned p);
    return (32'd1 << (l - 1)) / w_of(l, p);
  endfunction

  function automatic int unsigned rb_of(input int unsigned l, input int unsigned p);
    return (32'd1 << l) / r_of(l, p);
  endfunction

  function automatic int unsigned lw_of(input int unsigned n);
    return $clog2(layers_of(n) + 1);
  endfunction

  function automatic int unsigned cw_of(input int unsigned n, input int unsigned p);
    int unsigned c;
    c = $clog2(n / (2 * p));
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/ram_b_bank.sv
// One beta layer: storage, two-half write-beat overlay and read-beat mux.
// Optional RAM_B_BYPASS_EN makes same-cycle reads see this cycle's write.
module ram_b_bank
  import ram_b_pkg::*;
#(
  parameter int unsigned Q     = 6,
  parameter int unsigned P     = 64,
  parameter int unsigned N     = 1024,
  parameter int unsigned LAYER = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              we,
  input  logic [w_of(LAYER, P)*Q-1:0]       wr_lo,
  input  logic [w_of(LAYER, P)*Q-1:0]       wr_hi,
  input  logic [cw_of(N, P)-1:0]            cnt_w,
  input  logic [cw_of(N, P)-1:0]            cnt_r,
  output logic [P*Q-1:0]                    rd_vec_c
);

  localparam int unsigned W    = w_of(LAYER, P);
  localparam int unsigned R    = r_of(LAYER, P);
  localparam int unsigned RB   = rb_of(LAYER, P);
  localparam int unsigned HALF = 32'd1 << (LAYER - 1);
  localparam int unsigned CW   = cw_of(N, P);
  localparam int unsigned EW   = (32'd1 << LAYER) * Q;

  logic [EW-1:0] mem;
  logic [EW-1:0] mem_nxt_c;
  logic [EW-1:0] rd_src_c;

  // Overlay the addressed beat onto both halves of the bank
  always_comb begin
    mem_nxt_c = mem;
    if (we) begin
      for (int unsigned e = 0; e < HALF; e++) begin
        if (CW'(e / W) == cnt_w) begin
          mem_nxt_c[e*Q +: Q]          = wr_lo[(e % W)*Q +: Q];
          mem_nxt_c[(HALF + e)*Q +: Q] = wr_hi[(e % W)*Q +: Q];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else begin
      mem <= mem_nxt_c;
    end
  end

`ifdef RAM_B_BYPASS_EN
  assign rd_src_c = mem_nxt_c;
`else
  assign rd_src_c = mem;
`endif

  // Lanes beyond R stay zero for small layers
  always_comb begin
    rd_vec_c = '0;
    for (int unsigned k = 0; k < RB; k++) begin
      if (CW'(k) == cnt_r) begin
        for (int unsigned i = 0; i < R; i++) begin
          rd_vec_c[i*Q +: Q] = rd_src_c[(k*R + i)*Q +: Q];
        end
      end
    end
  end

endmodule

// File: rtl/ram_b_layered.sv
// Layered beta store for the SCAN polar decoder: L banks, registered read port, error flag.
// Define RAM_B_BYPASS_EN for write-first behaviour on same-layer read/write.
module ram_b_layered
  import ram_b_pkg::*;
#(
  parameter int unsigned Q = 6,
  parameter int unsigned P = 64,
  parameter int unsigned N = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2*P*Q-1:0]           b_in,
  input  logic [lw_of(N)-1:0]        layer_w,
  input  logic [cw_of(N, P)-1:0]     cnt_w,
  input  logic                       w_en,
  input  logic [lw_of(N)-1:0]        layer_r,
  input  logic [cw_of(N, P)-1:0]     cnt_r,
  input  logic                       r_en,
  output logic [P*Q-1:0]             b_out,
  output logic                       b_valid,
  output logic                       err
);

  localparam int unsigned L  = layers_of(N);
  localparam int unsigned LW = lw_of(N);
  localparam int unsigned CW = cw_of(N, P);

  logic [L:1]     wsel_c;
  logic [L:1]     rsel_c;
  logic [P*Q-1:0] rd_vec_c [1:L];
  logic [P*Q-1:0] rd_mux_c;
  logic           wr_bad_c;
  logic           rd_bad_c;

  // Per-layer legality decode doubles as the one-hot bank select
  for (genvar l = 1; l <= L; l++) begin : g_layer
    localparam int unsigned W = w_of(l, P);

    assign wsel_c[l] = w_en && (layer_w == LW'(l)) &&
                       ({1'b0, cnt_w} < (CW+1)'(wb_of(l, P)));
    assign rsel_c[l] = r_en && (layer_r == LW'(l)) &&
                       ({1'b0, cnt_r} < (CW+1)'(rb_of(l, P)));

    ram_b_bank #(
      .Q     (Q),
      .P     (P),
      .N     (N),
      .LAYER (l)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (wsel_c[l]),
      .wr_lo    (b_in[0 +: W*Q]),
      .wr_hi    (b_in[P*Q +: W*Q]),
      .cnt_w    (cnt_w),
      .cnt_r    (cnt_r),
      .rd_vec_c (rd_vec_c[l])
    );
  end

  always_comb begin
    rd_mux_c = '0;
    for (int unsigned l = 1; l <= L; l++) begin
      if (rsel_c[l]) begin
        rd_mux_c = rd_mux_c | rd_vec_c[l];
      end
    end
  end

  assign wr_bad_c = w_en && !(|wsel_c);
  assign rd_bad_c = r_en && !(|rsel_c);

  // Illegal or absent reads register zero data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_out   <= '0;
      b_valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      b_out   <= rd_mux_c;
      b_valid <= r_en;
      err     <= wr_bad_c | rd_bad_c;
    end
  end

endmodule
